// File: rtl/red_pitaya_mux_demux_if.sv
// Bus between the mux controller / ADC side and the mux demultiplexer.
// master drives the mux scan, ADC samples and acks; slave returns per-channel averages.
interface red_pitaya_mux_demux_if #(
  parameter int unsigned CHNL = 6,
  parameter int unsigned MAW  = 3,
  parameter int unsigned DW   = 14
);
  logic [MAW-1:0]     mux_addr_i;
  logic               signal_stable_i;
  logic [CHNL-1:0]    active_channels_i;
  logic [DW-1:0]      adc_dat_i;
  logic [CHNL-1:0]    ch_ack_i;
  logic               result_valid_o;
  logic [MAW-1:0]     result_ch_o;
  logic [DW-1:0]      result_dat_o;
  logic [CHNL*DW-1:0] ch_dat_o;
  logic [CHNL-1:0]    ch_fresh_o;
  logic [15:0]        abort_cnt_o;

  modport master (
    output mux_addr_i, signal_stable_i, active_channels_i, adc_dat_i, ch_ack_i,
    input  result_valid_o, result_ch_o, result_dat_o, ch_dat_o, ch_fresh_o, abort_cnt_o
  );

  modport slave (
    input  mux_addr_i, signal_stable_i, active_channels_i, adc_dat_i, ch_ack_i,
    output result_valid_o, result_ch_o, result_dat_o, ch_dat_o, ch_fresh_o, abort_cnt_o
  );
endinterface

// File: rtl/red_pitaya_mux_demux.sv
// Receive side of the analog-mux scan: averages 2**AVG_LOG2 settled ADC samples per dwell
// and keeps the latest average of every channel.
module red_pitaya_mux_demux #(
  parameter int unsigned CHNL     = 6,
  parameter int unsigned MAW      = 3,
  parameter int unsigned DW       = 14,
  parameter int unsigned AVG_LOG2 = 7
) (
  input logic                    adc_clk_i,
  input logic                    adc_rstn_i,
  red_pitaya_mux_demux_if.slave  bus
);

  localparam int unsigned AW         = DW + AVG_LOG2;
  localparam int unsigned CW         = AVG_LOG2 + 1;
  localparam int unsigned NumSamples = 1 << AVG_LOG2;
  localparam int unsigned AddrSpan   = 1 << MAW;

  typedef enum logic [1:0] {StIdle, StAccum, StDone, StHold} state_e;

  state_e                     state_q, state_d;
  logic [MAW-1:0]             cur_ch_q, cur_ch_d;
  logic signed [AW-1:0]       acc_q, acc_d, samp_ext, acc_sum, fin_acc;
  logic [CW-1:0]              cnt_q, cnt_d, cnt_inc;
  logic [15:0]                abort_q, abort_d;
  logic                       done;
  logic                       start;
  logic [AddrSpan-1:0]        act_pad;
  logic [DW-1:0]              avg;
  logic [CHNL-1:0][DW-1:0]    ch_dat_q, ch_dat_d;
  logic [CHNL-1:0]            fresh_q, fresh_d, set_mask;
  logic                       valid_q;
  logic [MAW-1:0]             res_ch_q;
  logic [DW-1:0]              res_dat_q;

  // Pad the enable mask to the full address space so out-of-range addresses read as disabled.
  always_comb begin
    act_pad             = '0;
    act_pad[CHNL-1:0]   = bus.active_channels_i;
  end

  assign start    = bus.signal_stable_i && (32'(bus.mux_addr_i) < CHNL) &&
                    act_pad[bus.mux_addr_i];
  assign samp_ext = AW'($signed(bus.adc_dat_i));
  assign acc_sum  = acc_q + samp_ext;
  assign cnt_inc  = cnt_q + CW'(1);
  // The start cycle already carries the first sample, so a 1-sample dwell completes there.
  assign fin_acc  = (state_q == StIdle) ? samp_ext : acc_sum;
  assign avg      = DW'(fin_acc >>> AVG_LOG2);

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_ch_d = bus.mux_addr_i;
          acc_d    = samp_ext;
          cnt_d    = CW'(1);
          if (cnt_d == CW'(NumSamples)) begin
            done    = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        // An address change wins over a sample that would complete the dwell.
        if ((bus.mux_addr_i != cur_ch_q) || !bus.signal_stable_i) begin
          abort_d = (abort_q == 16'hFFFF) ? abort_q : abort_q + 16'd1;
          state_d = StIdle;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(NumSamples)) begin
            done    = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StHold;
      StHold: begin
        if (bus.mux_addr_i != cur_ch_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    set_mask = '0;
    ch_dat_d = ch_dat_q;
    for (int unsigned n = 0; n < CHNL; n++) begin
      if (done && (cur_ch_d == MAW'(n))) begin
        set_mask[n] = 1'b1;
        ch_dat_d[n] = avg;
      end
    end
    // A set in the same cycle as an ack of that bit wins.
    fresh_d = (fresh_q & ~bus.ch_ack_i) | set_mask;
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q   <= StIdle;
      cur_ch_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      abort_q   <= '0;
      valid_q   <= 1'b0;
      res_ch_q  <= '0;
      res_dat_q <= '0;
      ch_dat_q  <= '0;
      fresh_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
      valid_q  <= done;
      if (done) begin
        res_ch_q  <= cur_ch_d;
        res_dat_q <= avg;
      end
      ch_dat_q <= ch_dat_d;
      fresh_q  <= fresh_d;
    end
  end

  assign bus.result_valid_o = valid_q;
  assign bus.result_ch_o    = res_ch_q;
  assign bus.result_dat_o   = res_dat_q;
  assign bus.ch_dat_o       = ch_dat_q;
  assign bus.ch_fresh_o     = fresh_q;
  assign bus.abort_cnt_o    = abort_q;

endmodule

// File: tb/tb_red_pitaya_mux_demux.sv
// Self-checking bench for red_pitaya_mux_demux: directed scenarios plus a randomized scan
// compared against a dwell-level behavioural model.
module tb_red_pitaya_mux_demux;
  localparam int CHNL = 6;
  localparam int MAW  = 3;
  localparam int DW   = 14;
  localparam int AVGL = 7;
  localparam int N    = 128;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  red_pitaya_mux_demux_if #(.CHNL(CHNL), .MAW(MAW), .DW(DW)) bus ();

  red_pitaya_mux_demux #(.CHNL(CHNL), .MAW(MAW), .DW(DW), .AVG_LOG2(AVGL)) dut (
    .adc_clk_i  (clk),
    .adc_rstn_i (rstn),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: a dwell in progress, the one-cycle result slot, and the
  // wait for the mux to move off a finished channel.
  bit                      m_busy, m_cool, m_hold;
  int                      m_ch, m_sum, m_n;
  bit                      exp_valid;
  int                      exp_ch, exp_dat, exp_abort;
  logic [CHNL-1:0][DW-1:0] exp_chdat;
  logic [CHNL-1:0]         exp_fresh;

  function automatic int floor_avg(int s);
    int r;
    r = s % N;
    if (r < 0) r += N;
    return (s - r) / N;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cool = 0; m_hold = 0; m_ch = 0; m_sum = 0; m_n = 0;
    exp_valid = 0; exp_ch = 0; exp_dat = 0; exp_abort = 0;
    exp_chdat = '0; exp_fresh = '0;
  endtask

  task automatic model_step(int a, bit s, logic [CHNL-1:0] act, int d, logic [CHNL-1:0] ack);
    exp_valid = 0;
    exp_fresh = exp_fresh & ~ack;
    if (m_cool) begin
      m_cool = 0;
      m_hold = 1;
    end else if (m_hold) begin
      if (a != m_ch) m_hold = 0;
    end else if (m_busy) begin
      if (a != m_ch || !s) begin
        m_busy = 0;
        if (exp_abort < 65535) exp_abort++;
      end else begin
        m_sum += d;
        m_n++;
        if (m_n == N) begin
          m_busy = 0;
          m_cool = 1;
          exp_valid = 1;
          exp_ch = m_ch;
          exp_dat = floor_avg(m_sum);
          exp_chdat[m_ch] = DW'(exp_dat);
          exp_fresh[m_ch] = 1'b1;
        end
      end
    end else if (s && a < CHNL && act[a]) begin
      m_busy = 1; m_ch = a; m_sum = d; m_n = 1;
    end
  endtask

  task automatic cyc(int a, bit s, logic [CHNL-1:0] act, int d, logic [CHNL-1:0] ack);
    bus.mux_addr_i        = MAW'(a);
    bus.signal_stable_i   = s;
    bus.active_channels_i = act;
    bus.adc_dat_i         = DW'(d);
    bus.ch_ack_i          = ack;
    @(posedge clk);
    model_step(a, s, act, d, ack);
    #1;
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) cyc(7, 1'b0, 6'h3f, 0, '0);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    bus.mux_addr_i = '0; bus.signal_stable_i = 1'b0; bus.active_channels_i = '0;
    bus.adc_dat_i = '0; bus.ch_ack_i = '0;
    rstn = 1'b0;
    #3;
    n_checks++; if (bus.result_valid_o !== 1'b0) begin n_errors++;
      $display("FAIL rst_valid got %0b want 0", bus.result_valid_o); end
    n_checks++; if (bus.result_ch_o !== '0) begin n_errors++;
      $display("FAIL rst_ch got %0d want 0", bus.result_ch_o); end
    n_checks++; if (bus.result_dat_o !== '0) begin n_errors++;
      $display("FAIL rst_dat got %0h want 0", bus.result_dat_o); end
    n_checks++; if (bus.ch_dat_o !== '0) begin n_errors++;
      $display("FAIL rst_ch_dat got %0h want 0", bus.ch_dat_o); end
    n_checks++; if (bus.ch_fresh_o !== '0) begin n_errors++;
      $display("FAIL rst_fresh got %0b want 0", bus.ch_fresh_o); end
    n_checks++; if (bus.abort_cnt_o !== '0) begin n_errors++;
      $display("FAIL rst_abort got %0d want 0", bus.abort_cnt_o); end
    apply_reset();
  endtask

  task automatic test_constant();
    int early = 0;
    for (int i = 0; i < N; i++) begin
      cyc(2, 1'b1, 6'h3f, 100, '0);
      if (i < N - 1 && bus.result_valid_o !== 1'b0) early++;
    end
    n_checks++; if (early != 0) begin n_errors++;
      $display("FAIL const_early got %0d want 0", early); end
    n_checks++; if (bus.result_valid_o !== 1'b1) begin n_errors++;
      $display("FAIL const_valid got %0b want 1", bus.result_valid_o); end
    n_checks++; if (bus.result_ch_o !== 3'd2) begin n_errors++;
      $display("FAIL const_ch got %0d want 2", bus.result_ch_o); end
    n_checks++; if (bus.result_dat_o !== 14'd100) begin n_errors++;
      $display("FAIL const_dat got %0d want 100", $signed(bus.result_dat_o)); end
    n_checks++; if (bus.ch_fresh_o !== 6'b000100) begin n_errors++;
      $display("FAIL const_fresh got %b want 000100", bus.ch_fresh_o); end
    cyc(2, 1'b1, 6'h3f, 100, '0);
    n_checks++; if (bus.result_valid_o !== 1'b0) begin n_errors++;
      $display("FAIL const_pulse got %0b want 0", bus.result_valid_o); end
    idle(1);
  endtask

  task automatic test_floor();
    for (int i = 0; i < N; i++) cyc(1, 1'b1, 6'h3f, (i % 2 == 0) ? -3 : 2, '0);
    n_checks++; if (bus.result_valid_o !== 1'b1) begin n_errors++;
      $display("FAIL floor_valid got %0b want 1", bus.result_valid_o); end
    n_checks++; if ($signed(bus.result_dat_o) !== -14'sd1) begin n_errors++;
      $display("FAIL floor_dat got %0d want -1", $signed(bus.result_dat_o)); end
    idle(2);
  endtask

  task automatic test_abort();
    int seen = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(2, 1'b1, 6'h3f, 7, '0);
      if (bus.result_valid_o) seen++;
    end
    cyc(3, 1'b1, 6'h3f, 9, '0);
    n_checks++; if (bus.abort_cnt_o !== 16'd1) begin n_errors++;
      $display("FAIL abort_cnt got %0d want 1", bus.abort_cnt_o); end
    for (int i = 0; i < N; i++) begin
      cyc(3, 1'b1, 6'h3f, 9, '0);
      if (i < N - 1 && bus.result_valid_o) seen++;
    end
    n_checks++; if (seen != 0) begin n_errors++;
      $display("FAIL abort_spurious got %0d want 0", seen); end
    n_checks++; if (bus.result_valid_o !== 1'b1 || bus.result_ch_o !== 3'd3) begin n_errors++;
      $display("FAIL abort_next got v%0b ch%0d want v1 ch3", bus.result_valid_o,
               bus.result_ch_o); end
    n_checks++; if (bus.result_dat_o !== 14'd9) begin n_errors++;
      $display("FAIL abort_next_dat got %0d want 9", $signed(bus.result_dat_o)); end
    idle(2);
  endtask

  task automatic test_scan();
    int q[$];
    logic [CHNL-1:0][DW-1:0] want;
    apply_reset();
    for (int c = 0; c < CHNL; c++) begin
      for (int i = 0; i < 140; i++) begin
        cyc(c, 1'b1, 6'b000101, 1000 + c, '0);
        if (bus.result_valid_o) q.push_back(int'(bus.result_ch_o));
      end
    end
    n_checks++; if (q.size() != 2) begin n_errors++;
      $display("FAIL scan_count got %0d want 2", q.size()); end
    else begin
      n_checks++; if (q[0] != 0 || q[1] != 2) begin n_errors++;
        $display("FAIL scan_order got %0d,%0d want 0,2", q[0], q[1]); end
    end
    want = '0;
    want[0] = 14'd1000;
    want[2] = 14'd1002;
    for (int c = 0; c < CHNL; c++) begin
      n_checks++;
      if (bus.ch_dat_o[c*DW +: DW] !== want[c]) begin n_errors++;
        $display("FAIL scan_ch_dat%0d got %0d want %0d", c, bus.ch_dat_o[c*DW +: DW], want[c]);
      end
    end
  endtask

  task automatic test_ack();
    cyc(7, 1'b0, 6'h3f, 0, 6'h3f);
    n_checks++; if (bus.ch_fresh_o !== 6'b0) begin n_errors++;
      $display("FAIL ack_clear got %b want 000000", bus.ch_fresh_o); end
    for (int i = 0; i < N; i++) cyc(2, 1'b1, 6'h3f, -20, (i == N - 1) ? 6'b000100 : 6'b0);
    n_checks++; if (bus.ch_fresh_o !== 6'b000100) begin n_errors++;
      $display("FAIL ack_set_wins got %b want 000100", bus.ch_fresh_o); end
    n_checks++; if ($signed(bus.ch_dat_o[2*DW +: DW]) !== -14'sd20) begin n_errors++;
      $display("FAIL ack_ch_dat got %0d want -20", $signed(bus.ch_dat_o[2*DW +: DW])); end
    cyc(2, 1'b1, 6'h3f, -20, 6'b000100);
    n_checks++; if (bus.ch_fresh_o !== 6'b0) begin n_errors++;
      $display("FAIL ack_clear2 got %b want 000000", bus.ch_fresh_o); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    int wait_cyc = 0;
    bit got = 0;
    for (int i = 0; i < 60; i++) cyc(4, 1'b1, 6'h3f, 500, '0);
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.result_valid_o !== 1'b0 || bus.result_ch_o !== '0 || bus.result_dat_o !== '0 ||
        bus.ch_dat_o !== '0 || bus.ch_fresh_o !== '0 || bus.abort_cnt_o !== '0) begin
      n_errors++;
      $display("FAIL mid_rst_outputs got v%0b ch%0d dat%0h chd%0h fr%b ab%0d want all 0",
               bus.result_valid_o, bus.result_ch_o, bus.result_dat_o, bus.ch_dat_o,
               bus.ch_fresh_o, bus.abort_cnt_o);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    while (!got && wait_cyc < 300) begin
      cyc(4, 1'b1, 6'h3f, wait_cyc, '0);
      wait_cyc++;
      if (bus.result_valid_o) got = 1;
    end
    n_checks++; if (!got || wait_cyc != N) begin n_errors++;
      $display("FAIL mid_rst_latency got %0d want %0d", wait_cyc, N); end
    n_checks++; if (bus.result_dat_o !== 14'd63 || bus.result_ch_o !== 3'd4) begin n_errors++;
      $display("FAIL mid_rst_dat got %0d ch%0d want 63 ch4", $signed(bus.result_dat_o),
               bus.result_ch_o); end
    idle(2);
  endtask

  task automatic test_random();
    logic [CHNL-1:0] act = 6'h3f;
    logic [CHNL-1:0] ack;
    bit prev_valid = 0;
    bit glitchy;
    int a, len, d;
    bit s;
    for (int seg = 0; seg < 30; seg++) begin
      a = $urandom_range(0, 7);
      len = $urandom_range(1, 180);
      glitchy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) act = CHNL'($urandom);
      for (int i = 0; i < len; i++) begin
        s = glitchy ? ($urandom_range(0, 59) != 0) : 1'b1;
        d = int'($urandom_range(0, 16383)) - 8192;
        ack = ($urandom_range(0, 9) == 0) ? CHNL'($urandom) : '0;
        cyc(a, s, act, d, ack);
        n_checks++; if (bus.result_valid_o !== exp_valid) begin n_errors++;
          $display("FAIL rnd_valid got %0b want %0b", bus.result_valid_o, exp_valid); end
        n_checks++; if (bus.result_ch_o !== MAW'(exp_ch)) begin n_errors++;
          $display("FAIL rnd_ch got %0d want %0d", bus.result_ch_o, exp_ch); end
        n_checks++; if (bus.result_dat_o !== DW'(exp_dat)) begin n_errors++;
          $display("FAIL rnd_dat got %0d want %0d", $signed(bus.result_dat_o), exp_dat); end
        n_checks++; if (bus.ch_dat_o !== exp_chdat) begin n_errors++;
          $display("FAIL rnd_ch_dat got %0h want %0h", bus.ch_dat_o, exp_chdat); end
        n_checks++; if (bus.ch_fresh_o !== exp_fresh) begin n_errors++;
          $display("FAIL rnd_fresh got %b want %b", bus.ch_fresh_o, exp_fresh); end
        n_checks++; if (bus.abort_cnt_o !== 16'(exp_abort)) begin n_errors++;
          $display("FAIL rnd_abort got %0d want %0d", bus.abort_cnt_o, exp_abort); end
        n_checks++; if (prev_valid && bus.result_valid_o === 1'b1) begin n_errors++;
          $display("FAIL rnd_double_pulse got 1 want 0"); end
        prev_valid = bus.result_valid_o;
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_floor();
    test_abort();
    test_scan();
    test_ack();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
